// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Latched result; CMP_EQ doubles as "no difference seen yet" while scanning.
  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, with optional MSB flip for
// two's-complement ordering of the top slice.
module cmp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             invert_msb_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    a_m            = a_i;
    b_m            = b_i;
    a_m[CHUNK-1]   = a_i[CHUNK-1] ^ invert_msb_i;
    b_m[CHUNK-1]   = b_i[CHUNK-1] ^ invert_msb_i;
  end

  assign gt_o = (a_m > b_m);
  assign eq_o = (a_m == b_m);
  assign lt_o = (a_m < b_m);

endmodule

// File: rtl/mag_comparator_seq.sv
// Sequential magnitude comparator: scans operands CHUNK bits per cycle from the MSB end,
// optionally stopping at the first differing chunk, and pulses a one-hot result.
module mag_comparator_seq
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             signed_mode_i,
  output logic             out_valid_o,
  output logic             a_gt_b_o,
  output logic             a_eq_b_o,
  output logic             a_lt_b_o,
  output logic             busy_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = idx_width(NCHUNK);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NCHUNK - 1);

  if ((CHUNK == 0) || (NCHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : gen_param_check
    $error("mag_comparator_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic [2:0]       flags_q, flags_d;  // {gt, eq, lt}

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_gt, chunk_eq, chunk_lt;
  logic [1:0]       chunk_res;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IdxW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i          (chunk_a),
    .b_i          (chunk_b),
    .invert_msb_i (signed_q && (idx_q == IdxTop)),
    .gt_o         (chunk_gt),
    .eq_o         (chunk_eq),
    .lt_o         (chunk_lt)
  );

  always_comb begin
    chunk_res = CMP_EQ;
    if (chunk_gt) begin
      chunk_res = CMP_GT;
    end else if (chunk_lt) begin
      chunk_res = CMP_LT;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    res_d    = res_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (in_valid_i) begin
          a_d      = data_a_i;
          b_d      = data_b_i;
          signed_d = signed_mode_i;
          idx_d    = IdxTop;
          res_d    = CMP_EQ;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        // Keep the most significant difference once one has been seen.
        res_d = (res_q != CMP_EQ) ? res_q : chunk_res;
        if ((idx_q == '0) || (EARLY_EXIT && !chunk_eq)) begin
          state_d = StDone;
          flags_d = {res_d == CMP_GT, res_d == CMP_EQ, res_d == CMP_LT};
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= CMP_EQ;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready_o  = rst_ni && ((state_q == StIdle) || (state_q == StDone));
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StCmp);
  assign a_gt_b_o    = flags_q[2];
  assign a_eq_b_o    = flags_q[1];
  assign a_lt_b_o    = flags_q[0];

endmodule
